// File: rtl/alu_fmt_pkg.sv
// Shared field layout, FSM encoding and default sizes for the ALU result word decoder.
// Field positions are offsets above MAG_W so they track the magnitude width.
package alu_fmt_pkg;

  localparam int DEF_MAG_W = 8;
  localparam int DEF_NDIG  = 3;

  localparam int OP_HI    = 3;
  localparam int OP_LO    = 2;
  localparam int IGN_BIT  = 1;
  localparam int SIGN_BIT = 0;
  localparam int MAG_HI   = -1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_result_decoder_bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/alu_result_decoder.sv
// Captures one ALU result word, converts its magnitude to packed BCD bit-serially
// and holds sign, digits and op until the downstream consumer accepts them.
module alu_result_decoder
  import alu_fmt_pkg::*;
#(
  parameter int MAG_W = DEF_MAG_W,
  parameter int NDIG  = DEF_NDIG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAG_W+3:0]   in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [1:0]         out_op,
  output logic               out_neg,
  output logic               out_zero,
  output logic [4*NDIG-1:0]  out_bcd,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int BCD_W = 4 * NDIG;
  localparam int SR_W  = BCD_W + MAG_W;
  localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SR_W-1:0]  shift_q;
  logic [SR_W-1:0]  shift_d;
  logic [BCD_W-1:0] bcd_fix_s;
  logic [1:0]       op_q;
  logic             neg_q;
  logic             zero_q;
  logic [MAG_W-1:0] mag_s;
  logic             unused_ign;

  assign mag_s      = in_word[MAG_W+MAG_HI:0];
  assign unused_ign = in_word[MAG_W+IGN_BIT];
  assign in_ready   = (state_q == IDLE);

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_add3 u_add3 (
      .d_i (shift_q[MAG_W+4*g +: 4]),
      .d_o (bcd_fix_s[4*g +: 4])
    );
  end

  // Corrected digits and remaining magnitude bits shift left together.
  assign shift_d = {bcd_fix_s[BCD_W-2:0], shift_q[MAG_W-1:0], 1'b0};

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      op_q      <= 2'b00;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      out_op    <= 2'b00;
      out_neg   <= 1'b0;
      out_zero  <= 1'b0;
      out_bcd   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q <= {{BCD_W{1'b0}}, mag_s};
            cnt_q   <= '0;
            op_q    <= in_word[MAG_W+OP_HI:MAG_W+OP_LO];
            neg_q   <= in_word[MAG_W+SIGN_BIT] & (|mag_s);
            zero_q  <= ~(|mag_s);
            state_q <= CONV;
          end
        end
        CONV: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            out_bcd   <= shift_d[SR_W-1:MAG_W];
            out_op    <= op_q;
            out_neg   <= neg_q;
            out_zero  <= zero_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed results and latencies, a monitor pops on output.
module tb_alu_result_decoder;

  typedef struct packed {
    logic [1:0]  op;
    logic        neg;
    logic        zero;
    logic [11:0] bcd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] in_word = 12'h000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  out_op;
  logic        out_neg;
  logic        out_zero;
  logic [11:0] out_bcd;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;
  exp_t exp_q[$];
  int   lat_q[$];

  alu_result_decoder #(.MAG_W(8), .NDIG(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_op    (out_op),
    .out_neg   (out_neg),
    .out_zero  (out_zero),
    .out_bcd   (out_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: latency on each rising out_valid, result on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_v) begin
        if (lat_q.size() == 0) fail_now("unexpected_valid");
        else chk("latency", 16'(cyc), 16'(lat_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else chk("result", {out_op, out_neg, out_zero, out_bcd}, exp_q.pop_front());
      end
    end
    prev_v <= out_valid;
  end

  // Call at a negedge; waits for in_ready, scores the word and lets it be accepted.
  task automatic send(input logic [11:0] w, input exp_t e);
    bit ok = 1'b0;
    in_word  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("send_ready");
    exp_q.push_back(e);
    lat_q.push_back(cyc + 9);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_valid");
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain");
  endtask

  initial begin
    logic [11:0] wx;
    #1 rst = 1'b1;
    #1;
    chk("reset_outs", {out_op, out_neg, out_zero, out_valid, out_bcd[10:0]}, 16'h0000);
    chk("reset_ready", 16'(in_ready), 16'h0001);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Test 1: -13, op 01, single-cycle valid
    @(negedge clk);
    send(12'h50D, '{op: 2'b01, neg: 1'b1, zero: 1'b0, bcd: 12'h013});
    wait_valid();
    @(negedge clk);
    chk("valid_one_cycle", 16'(out_valid), 16'h0000);
    drain();

    // Test 2: 255
    @(negedge clk);
    send(12'h0FF, '{op: 2'b00, neg: 1'b0, zero: 1'b0, bcd: 12'h255});
    drain();

    // Test 3: negative zero normalised
    @(negedge clk);
    send(12'h500, '{op: 2'b01, neg: 1'b0, zero: 1'b1, bcd: 12'h000});
    drain();

    // Test 4: ignored bit set, then unknown
    @(negedge clk);
    send(12'h6C8, '{op: 2'b01, neg: 1'b0, zero: 1'b0, bcd: 12'h200});
    drain();
    wx = 12'h4C8;
    wx[9] = 1'bx;
    @(negedge clk);
    send(wx, '{op: 2'b01, neg: 1'b0, zero: 1'b0, bcd: 12'h200});
    drain();

    // Test 5: backpressure with a pending new word
    out_ready = 1'b0;
    @(negedge clk);
    send(12'hD2A, '{op: 2'b11, neg: 1'b1, zero: 1'b0, bcd: 12'h042});
    wait_valid();
    in_word  = 12'h87B;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 16'(in_ready), 16'h0000);
      chk("bp_valid", 16'(out_valid), 16'h0001);
      chk("bp_hold", {out_op, out_neg, out_zero, out_bcd}, {2'b11, 1'b1, 1'b0, 12'h042});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_done", 16'(in_ready), 16'h0000);
    @(negedge clk);
    chk("bp_idle_ready", 16'(in_ready), 16'h0001);
    chk("bp_idle_valid", 16'(out_valid), 16'h0000);
    send(12'h87B, '{op: 2'b10, neg: 1'b0, zero: 1'b0, bcd: 12'h123});
    @(negedge clk);
    chk("bp_taken", 16'(in_ready), 16'h0000);
    drain();

    // Test 6: async reset mid-conversion, then 99
    @(negedge clk);
    send(12'h7AB, '{op: 2'b01, neg: 1'b1, zero: 1'b0, bcd: 12'h171});
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    lat_q.delete();
    chk("abort_outs", {out_op, out_neg, out_zero, out_valid, out_bcd[10:0]}, 16'h0000);
    chk("abort_bcd_msb", 16'(out_bcd[11]), 16'h0000);
    chk("abort_ready", 16'(in_ready), 16'h0001);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("abort_no_valid", 16'(out_valid), 16'h0000);
    send(12'h463, '{op: 2'b01, neg: 1'b0, zero: 1'b0, bcd: 12'h099});
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
